decode_stage: RTL and testbench

//  ID stage between fetch and execute. Decodes the instruction word and reads rs/rd from an internal
//  16-entry register file, which execute writes back through wb_*. Detects read-after-write hazards.

---
 rtl/decode_stage.sv | 145 ++++++++++++++
 tb/tb_decode_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ID stage: decodes the instruction, reads a 16-entry register file and detects RAW hazards into the ID/EX register.
// Optional macro DECODE_BYPASS_EN forwards same-cycle write-back data instead of stalling for it.
module decode_stage #(
    parameter int WORD   = 32,
    parameter int ADDR   = 16,
    parameter int W_RD   = 4,
    parameter int W_DOPC = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    input  logic [WORD-1:0]   inst_i,
    input  logic [ADDR-1:0]   pc_i,
    output logic              stall_o,
    input  logic              branch_i,
    input  logic              stall_i,
    output logic              v_o,
    output logic [WORD-1:0]   src_o,
    output logic [WORD-1:0]   dest_o,
    output logic              wb_o,
    output logic [W_RD-1:0]   wb_rd_name_o,
    output logic [W_DOPC-1:0] dopc_o,
    output logic [3:0]        opc_o,
    output logic [ADDR-1:0]   origaddr_o,
    output logic [3:0]        cc_o,
    output logic [ADDR-1:0]   dm_addr_o,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   wb_rd_name_i,
    input  logic [WORD-1:0]   wb_rd_data_i
);
    localparam int NREG = 1 << W_RD;

    logic [WORD-1:0]   rf_q [NREG];

    logic              v_q;
    logic [WORD-1:0]   src_q;
    logic [WORD-1:0]   dest_q;
    logic              wb_q;
    logic [W_RD-1:0]   wb_rd_name_q;
    logic [W_DOPC-1:0] dopc_q;
    logic [3:0]        opc_q;
    logic [ADDR-1:0]   origaddr_q;
    logic [3:0]        cc_q;

    logic [3:0]        cls;
    logic [W_RD-1:0]   rd_idx;
    logic [W_RD-1:0]   rs_idx;
    logic              imm_f;
    logic [WORD-1:0]   imm_sext;
    logic              cls_valid;
    logic              wb_dec;
    logic [W_DOPC-1:0] dopc_dec;
    logic [3:0]        cc_dec;
    logic              rs_used;
    logic              rd_used;
    logic              pend_v;
    logic [W_RD-1:0]   pend_rd;
    logic              haz_a;
    logic              haz_b;
    logic              hazard;
    logic [WORD-1:0]   rs_val;
    logic [WORD-1:0]   rd_val;
    logic [WORD-1:0]   src_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_i) begin
            rf_q[wb_rd_name_i] <= wb_rd_data_i;
        end
    end

    always_comb begin
        cls       = inst_i[31:28];
        rd_idx    = W_RD'(inst_i[23:20]);
        rs_idx    = W_RD'(inst_i[19:16]);
        imm_f     = inst_i[15];
        imm_sext  = {{(WORD-15){inst_i[14]}}, inst_i[14:0]};
        cls_valid = (cls <= 4'd10);
        wb_dec    = (cls <= 4'd7);
        dopc_dec  = cls_valid ? (W_DOPC'(1) << cls) : '0;
        cc_dec    = (cls == 4'd9) ? inst_i[23:20] : 4'd0;
        rs_used   = !imm_f;
        rd_used   = wb_dec || (cls == 4'd8) || (cls == 4'd9);
    end

    // The instruction now in ID/EX has not produced its result on wb_i yet.
    assign pend_v  = v_q & wb_q;
    assign pend_rd = wb_rd_name_q;
    assign haz_a   = pend_v && ((rs_used && rs_idx == pend_rd) || (rd_used && rd_idx == pend_rd));

`ifdef DECODE_BYPASS_EN
    assign haz_b  = 1'b0;
    assign rs_val = (wb_i && wb_rd_name_i == rs_idx) ? wb_rd_data_i : rf_q[rs_idx];
    assign rd_val = (wb_i && wb_rd_name_i == rd_idx) ? wb_rd_data_i : rf_q[rd_idx];
`else
    // Without forwarding, wait until the write-back has landed in the register file.
    assign haz_b  = wb_i && ((rs_used && rs_idx == wb_rd_name_i) || (rd_used && rd_idx == wb_rd_name_i));
    assign rs_val = rf_q[rs_idx];
    assign rd_val = rf_q[rd_idx];
`endif

    assign hazard  = v_i & (haz_a | haz_b);
    assign stall_o = v_i & (hazard | stall_i) & ~branch_i;
    assign src_d   = imm_f ? imm_sext : rs_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q          <= 1'b0;
            src_q        <= '0;
            dest_q       <= '0;
            wb_q         <= 1'b0;
            wb_rd_name_q <= '0;
            dopc_q       <= '0;
            opc_q        <= '0;
            origaddr_q   <= '0;
            cc_q         <= '0;
        end else if (branch_i || (!stall_i && hazard)) begin
            v_q    <= 1'b0;
            wb_q   <= 1'b0;
            dopc_q <= '0;
        end else if (!stall_i) begin
            v_q          <= v_i;
            src_q        <= src_d;
            dest_q       <= rd_val;
            wb_q         <= v_i & wb_dec;
            wb_rd_name_q <= rd_idx;
            dopc_q       <= v_i ? dopc_dec : '0;
            opc_q        <= inst_i[27:24];
            origaddr_q   <= pc_i;
            cc_q         <= cc_dec;
        end
    end

    assign v_o          = v_q;
    assign src_o        = src_q;
    assign dest_o       = dest_q;
    assign wb_o         = wb_q;
    assign wb_rd_name_o = wb_rd_name_q;
    assign dopc_o       = dopc_q;
    assign opc_o        = opc_q;
    assign origaddr_o   = origaddr_q;
    assign cc_o         = cc_q;
    assign dm_addr_o    = src_q[ADDR-1:0];
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus hazard, stall, flush and reset sequences.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [15:0] pc_i = '0;
    logic        stall_o;
    logic        branch_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        v_o;
    logic [31:0] src_o, dest_o;
    logic        wb_o;
    logic [3:0]  wb_rd_name_o;
    logic [10:0] dopc_o;
    logic [3:0]  opc_o;
    logic [15:0] origaddr_o;
    logic [3:0]  cc_o;
    logic [15:0] dm_addr_o;
    logic        wb_i = 1'b0;
    logic [3:0]  wb_rd_name_i = '0;
    logic [31:0] wb_rd_data_i = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i), .stall_o(stall_o),
        .branch_i(branch_i), .stall_i(stall_i), .v_o(v_o), .src_o(src_o), .dest_o(dest_o),
        .wb_o(wb_o), .wb_rd_name_o(wb_rd_name_o), .dopc_o(dopc_o), .opc_o(opc_o),
        .origaddr_o(origaddr_o), .cc_o(cc_o), .dm_addr_o(dm_addr_o), .wb_i(wb_i),
        .wb_rd_name_i(wb_rd_name_i), .wb_rd_data_i(wb_rd_data_i)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] src;
        logic [31:0] dest;
        logic        wb;
        logic [3:0]  rd;
        logic [10:0] dopc;
        logic [3:0]  opc;
        logic [3:0]  cc;
        logic [15:0] dm;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int cls, input int opc, input int rd, input int rs,
                                       input int immf, input int imm);
        logic [31:0] w;
        w = {cls[3:0], opc[3:0], rd[3:0], rs[3:0], immf[0], imm[14:0]};
        return w;
    endfunction

    initial begin
        int bubbles;
        int exp_bubbles;
        bit issued;
        logic [31:0] pl_data [4];
        logic [3:0]  pl_rd   [4];

`ifdef DECODE_BYPASS_EN
        exp_bubbles = 1;
`else
        exp_bubbles = 2;
`endif
        vecs[0] = '{mk(0,1,2,1,0,0),         32'h0000_0005, 32'h0000_1234, 1'b1, 4'd2, 11'h001, 4'd1, 4'd0, 16'h0005};
        vecs[1] = '{mk(7,0,6,0,1,'h7FFF),    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'd6, 11'h080, 4'd0, 4'd0, 16'hFFFF};
        vecs[2] = '{mk(9,2,5,3,0,0),         32'hFFFF_0000, 32'hA5A5_A5A5, 1'b0, 4'd5, 11'h200, 4'd2, 4'd5, 16'h0000};
        vecs[3] = '{mk(12,3,1,2,0,0),        32'h0000_1234, 32'h0000_0005, 1'b0, 4'd1, 11'h000, 4'd3, 4'd0, 16'h1234};
        vecs[4] = '{mk(8,0,5,0,1,'h10),      32'h0000_0010, 32'hA5A5_A5A5, 1'b0, 4'd5, 11'h100, 4'd0, 4'd0, 16'h0010};
        vecs[5] = '{mk(10,0,0,0,0,0),        32'h0000_0000, 32'h0000_0000, 1'b0, 4'd0, 11'h400, 4'd0, 4'd0, 16'h0000};
        vecs[6] = '{mk(4,5,3,0,1,'h4000),    32'hFFFF_C000, 32'hFFFF_0000, 1'b1, 4'd3, 11'h010, 4'd5, 4'd0, 16'hC000};
        vecs[7] = '{mk(15,0,0,0,0,0),        32'h0000_0000, 32'h0000_0000, 1'b0, 4'd0, 11'h000, 4'd0, 4'd0, 16'h0000};

        pl_rd[0] = 4'd2; pl_data[0] = 32'h0000_1234;
        pl_rd[1] = 4'd3; pl_data[1] = 32'hFFFF_0000;
        pl_rd[2] = 4'd5; pl_data[2] = 32'hA5A5_A5A5;
        pl_rd[3] = 4'd1; pl_data[3] = 32'h0000_0005;

        // Reset state
        step();
        step();
        chk("reset_v_o", 32'(v_o), 32'd0);
        chk("reset_src_o", src_o, 32'd0);
        chk("reset_dopc_o", 32'(dopc_o), 32'd0);
        chk("reset_stall_o", 32'(stall_o), 32'd0);
        rst = 1'b1;
        step();

        // Preload registers; r1 is written in the cycle right before the first vector issues
        for (int i = 0; i < 4; i++) begin
            wb_i = 1'b1; wb_rd_name_i = pl_rd[i]; wb_rd_data_i = pl_data[i];
            step();
        end
        wb_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            v_i = 1'b1; inst_i = vecs[i].inst; pc_i = 16'h0100 + 16'(i * 4);
            step();
            chk($sformatf("vec%0d_v_o", i), 32'(v_o), 32'd1);
            chk($sformatf("vec%0d_src_o", i), src_o, vecs[i].src);
            chk($sformatf("vec%0d_dest_o", i), dest_o, vecs[i].dest);
            chk($sformatf("vec%0d_wb_o", i), 32'(wb_o), 32'(vecs[i].wb));
            chk($sformatf("vec%0d_rd", i), 32'(wb_rd_name_o), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_dopc_o", i), 32'(dopc_o), 32'(vecs[i].dopc));
            chk($sformatf("vec%0d_opc_o", i), 32'(opc_o), 32'(vecs[i].opc));
            chk($sformatf("vec%0d_cc_o", i), 32'(cc_o), 32'(vecs[i].cc));
            chk($sformatf("vec%0d_dm_addr_o", i), 32'(dm_addr_o), 32'(vecs[i].dm));
            chk($sformatf("vec%0d_origaddr_o", i), 32'(origaddr_o), 32'(16'h0100 + 16'(i * 4)));
            v_i = 1'b0;
            step();
        end

        // Back-to-back dependency: ADD r2,r1 then ADD r3,r2, execute writes r2=0x77 one cycle later
        v_i = 1'b1; inst_i = mk(0,0,2,1,0,0); pc_i = 16'h0200;
        step();
        chk("raw_first_v_o", 32'(v_o), 32'd1);
        inst_i = mk(0,0,3,2,0,0); pc_i = 16'h0204;
        #1;
        chk("raw_hazA_stall_o", 32'(stall_o), 32'd1);
        step();
        chk("raw_bubble1_v_o", 32'(v_o), 32'd0);
        bubbles = 1;
        issued = 1'b0;
        for (int k = 1; k <= 6 && !issued; k++) begin
            wb_i = (k == 1); wb_rd_name_i = 4'd2; wb_rd_data_i = 32'h0000_0077;
            step();
            if (v_o) issued = 1'b1;
            else bubbles++;
        end
        wb_i = 1'b0;
        chk("raw_issued", 32'(issued), 32'd1);
        chk("raw_bubbles", 32'(bubbles), 32'(exp_bubbles));
        chk("raw_src_o", src_o, 32'h0000_0077);
        chk("raw_dest_o", dest_o, 32'hFFFF_0000);
        chk("raw_origaddr_o", 32'(origaddr_o), 32'h0000_0204);
        v_i = 1'b0;
        step();

        // stall_i held for 3 cycles with a waiting instruction
        v_i = 1'b1; inst_i = mk(0,0,4,5,0,0); pc_i = 16'h0300;
        step();
        chk("stl_first_src_o", src_o, 32'hA5A5_A5A5);
        inst_i = mk(1,0,6,7,0,0); pc_i = 16'h0304; stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stl%0d_stall_o", k), 32'(stall_o), 32'd1);
            step();
            chk($sformatf("stl%0d_v_o", k), 32'(v_o), 32'd1);
            chk($sformatf("stl%0d_dopc_o", k), 32'(dopc_o), 32'h001);
            chk($sformatf("stl%0d_src_o", k), src_o, 32'hA5A5_A5A5);
            chk($sformatf("stl%0d_origaddr_o", k), 32'(origaddr_o), 32'h0000_0300);
        end
        stall_i = 1'b0;
        #1;
        chk("stl_release_stall_o", 32'(stall_o), 32'd0);
        step();
        chk("stl_next_v_o", 32'(v_o), 32'd1);
        chk("stl_next_dopc_o", 32'(dopc_o), 32'h002);
        chk("stl_next_origaddr_o", 32'(origaddr_o), 32'h0000_0304);
        v_i = 1'b0;
        step();

        // Flush together with stall_i and a hazard
        v_i = 1'b1; inst_i = mk(0,0,2,1,0,0); pc_i = 16'h0400;
        step();
        chk("br_first_v_o", 32'(v_o), 32'd1);
        inst_i = mk(0,0,3,2,0,0); pc_i = 16'h0404; stall_i = 1'b1; branch_i = 1'b1;
        #1;
        chk("br_stall_o", 32'(stall_o), 32'd0);
        step();
        chk("br_v_o", 32'(v_o), 32'd0);
        chk("br_dopc_o", 32'(dopc_o), 32'd0);
        chk("br_wb_o", 32'(wb_o), 32'd0);
        branch_i = 1'b0; stall_i = 1'b0; v_i = 1'b0;
        step();

        // Reset mid-stream
        v_i = 1'b1; inst_i = mk(0,0,1,2,0,0); pc_i = 16'h0500;
        step();
        rst = 1'b0;
        step();
        chk("mrst_v_o", 32'(v_o), 32'd0);
        chk("mrst_src_o", src_o, 32'd0);
        chk("mrst_dest_o", dest_o, 32'd0);
        chk("mrst_wb_o", 32'(wb_o), 32'd0);
        chk("mrst_dopc_o", 32'(dopc_o), 32'd0);
        chk("mrst_origaddr_o", 32'(origaddr_o), 32'd0);
        chk("mrst_stall_o", 32'(stall_o), 32'd0);
        rst = 1'b1;
        for (int i = 1; i < 16; i++) begin
            inst_i = mk(0,0,i,i,0,0); pc_i = 16'h0600 + 16'(i);
            step();
            chk($sformatf("clr_r%0d_v_o", i), 32'(v_o), 32'd1);
            chk($sformatf("clr_r%0d_src_o", i), src_o, 32'd0);
            chk($sformatf("clr_r%0d_dest_o", i), dest_o, 32'd0);
        end
        v_i = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
